// File: rtl/senha_entrada.sv
// Keypad front-end: collects up to 3 decimal digits, converts to binary and hands the
// value to the access controller with an enter pulse; handles clear, timeout and >255 rejection.
module senha_entrada #(
    parameter int TIMEOUT      = 1000,
    parameter int ENTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tecla,
    input  logic       tecla_valida,
    output logic [7:0] senha,
    output logic       enter,
    output logic       erro,
    output logic [1:0] digitos
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLETA = 2'd1,
        ENVIA  = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  ENT_N    = 4'(ENTER_CYCLES);

    state_t      state_q;
    logic        tv_prev_q;
    logic [9:0]  acc_q;
    logic [15:0] tmr_q;
    logic [3:0]  ent_cnt_q;
    logic [7:0]  senha_q;
    logic        enter_q;
    logic        erro_q;
    logic [1:0]  digitos_q;

    logic        key_evt_d;
    logic        is_digit_d;
    logic        is_clear_d;
    logic        is_conf_d;
    logic [9:0]  acc_d;

    // Rising edge of the held-key level gives exactly one event per press.
    assign key_evt_d  = tecla_valida & ~tv_prev_q;
    assign is_digit_d = (tecla <= 4'd9);
    assign is_clear_d = (tecla == 4'hA);
    assign is_conf_d  = (tecla == 4'hB);
    assign acc_d      = (acc_q * 10'd10) + {6'd0, tecla};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tv_prev_q <= 1'b0;
            acc_q     <= '0;
            tmr_q     <= '0;
            ent_cnt_q <= '0;
            senha_q   <= '0;
            enter_q   <= 1'b0;
            erro_q    <= 1'b0;
            digitos_q <= '0;
        end else begin
            tv_prev_q <= tecla_valida;
            erro_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    enter_q <= 1'b0;
                    tmr_q   <= '0;
                    if (key_evt_d && is_digit_d) begin
                        acc_q     <= {6'd0, tecla};
                        digitos_q <= 2'd1;
                        state_q   <= COLETA;
                    end
                end
                COLETA: begin
                    if (key_evt_d) begin
                        tmr_q <= '0;
                        if (is_digit_d) begin
                            // A fourth digit is silently dropped.
                            if (digitos_q != 2'd3) begin
                                acc_q     <= acc_d;
                                digitos_q <= digitos_q + 2'd1;
                            end
                        end else if (is_clear_d) begin
                            acc_q     <= '0;
                            digitos_q <= '0;
                            state_q   <= IDLE;
                        end else if (is_conf_d) begin
                            acc_q     <= '0;
                            digitos_q <= '0;
                            if (acc_q <= 10'd255) begin
                                senha_q   <= acc_q[7:0];
                                ent_cnt_q <= '0;
                                state_q   <= ENVIA;
                            end else begin
                                erro_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end else if (tmr_q == TMO_LAST) begin
                        acc_q     <= '0;
                        digitos_q <= '0;
                        tmr_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + 16'd1;
                    end
                end
                ENVIA: begin
                    if (ent_cnt_q < ENT_N) begin
                        enter_q   <= 1'b1;
                        ent_cnt_q <= ent_cnt_q + 4'd1;
                    end else begin
                        enter_q   <= 1'b0;
                        ent_cnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign senha   = senha_q;
    assign enter   = enter_q;
    assign erro    = erro_q;
    assign digitos = digitos_q;

endmodule

// File: tb/tb_senha_entrada.sv
// Directed bench for senha_entrada with short timeout and two-cycle enter window.
module tb_senha_entrada;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tecla;
    logic       tecla_valida;
    logic [7:0] senha;
    logic       enter;
    logic       erro;
    logic [1:0] digitos;

    int total = 0;
    int bad   = 0;

    senha_entrada #(.TIMEOUT(50), .ENTER_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .senha        (senha),
        .enter        (enter),
        .erro         (erro),
        .digitos      (digitos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press a key for 'hold' clocks, release, then one idle clock.
    task automatic press(input logic [3:0] k, input int hold);
        @(posedge clk); #1;
        tecla = k;
        tecla_valida = 1'b1;
        repeat (hold) @(posedge clk);
        #1 tecla_valida = 1'b0;
        @(posedge clk); #1;
    endtask

    // Confirm key held 3 clocks; checks senha/erro/enter cycle by cycle.
    task automatic confirm(input string tag, input int exp_enter, input int exp_senha, input int exp_erro);
        @(posedge clk); #1;
        tecla = 4'hB;
        tecla_valida = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_senha"}, senha, exp_senha);
        chk({tag, "_dig0"}, digitos, 0);
        chk({tag, "_erro_n"}, erro, exp_erro);
        chk({tag, "_enter_n"}, enter, 0);
        @(posedge clk); #1;
        chk({tag, "_enter_n1"}, enter, exp_enter);
        chk({tag, "_erro_n1"}, erro, 0);
        @(posedge clk); #1;
        chk({tag, "_enter_n2"}, enter, exp_enter);
        chk({tag, "_senha_n2"}, senha, exp_senha);
        tecla_valida = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_enter_n3"}, enter, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        tecla = 4'd0;
        tecla_valida = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_senha", senha, 0);
        chk("rst_enter", enter, 0);
        chk("rst_erro", erro, 0);
        chk("rst_dig", digitos, 0);
        rst = 1'b0;

        // 2,0,0,# -> 200
        press(4'd2, 3); chk("p200_d1", digitos, 1);
        press(4'd0, 3); chk("p200_d2", digitos, 2);
        press(4'd0, 3); chk("p200_d3", digitos, 3);
        confirm("p200", 1, 200, 0);

        // 3,0,0,# -> rejected, senha keeps 200
        press(4'd3, 3);
        press(4'd0, 3);
        press(4'd0, 3); chk("p300_d3", digitos, 3);
        confirm("p300", 0, 200, 1);

        // 1,9,9,5,# -> fourth digit dropped
        press(4'd1, 3);
        press(4'd9, 3);
        press(4'd9, 3); chk("p199_d3", digitos, 3);
        press(4'd5, 3); chk("p199_d4", digitos, 3);
        confirm("p199", 1, 199, 0);

        // 4,5,*,1,# -> 1
        press(4'd4, 3);
        press(4'd5, 3); chk("clr_d2", digitos, 2);
        press(4'hA, 3); chk("clr_d0", digitos, 0);
        press(4'd1, 3); chk("clr_d1", digitos, 1);
        confirm("p1", 1, 1, 0);

        // 7, idle timeout, # does nothing, then 8,# -> 8
        press(4'd7, 3); chk("tmo_d1", digitos, 1);
        repeat (40) @(posedge clk);
        #1 chk("tmo_early", digitos, 1);
        repeat (20) @(posedge clk);
        #1 chk("tmo_d0", digitos, 0);
        confirm("tmo_conf", 0, 1, 0);
        press(4'd8, 3); chk("p8_d1", digitos, 1);
        confirm("p8", 1, 8, 0);

        // Long hold counts once
        press(4'd5, 20); chk("hold_d1", digitos, 1);
        confirm("p5", 1, 5, 0);

        // Reset during enter window
        press(4'd9, 3);
        @(posedge clk); #1;
        tecla = 4'hB;
        tecla_valida = 1'b1;
        @(posedge clk); #1;
        chk("rstw_senha", senha, 9);
        @(posedge clk); #1;
        chk("rstw_enter1", enter, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_enter0", enter, 0);
        chk("rstw_senha0", senha, 0);
        chk("rstw_dig0", digitos, 0);
        tecla_valida = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstw_after", enter, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/senha_entrada.md
Name: senha_entrada

Overview:
- Keypad front-end directly upstream of acess_ctrl.
- Collects up to 3 decimal digits from a 4-bit keypad code stream and converts them to binary.
- On confirm key, presents the 8-bit value on senha and holds enter high for ENTER_CYCLES clocks; acess_ctrl consumes senha/enter.
- Also handles clear, per-entry inactivity timeout and out-of-range (>255) rejection.

Parameters:
- TIMEOUT, 1000, idle clocks in COLETA before the partial entry is discarded (1 to 2^16-1).
- ENTER_CYCLES, 2, number of clocks enter stays high per accepted entry (1 to 15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tecla  input  4  keypad code: 0-9 digit, 4'hA clear (*), 4'hB confirm (#), 4'hC-4'hF ignored.
- tecla_valida  input  1  level from keypad, high while a key is held; sampled synchronously.
- senha  output  8  binary value of last accepted entry, to acess_ctrl senha_digitada.
- enter  output  1  high for ENTER_CYCLES clocks after an accepted entry, to acess_ctrl enter.
- erro  output  1  one-clock pulse on rejected entry (value >255).
- digitos  output  2  digits collected so far in the current entry (0-3), for display.

Behaviour:
- Reset (async, rst=1): senha=0, enter=0, erro=0, digitos=0, acc=0, timeout counter=0, tv_prev=0, state=IDLE.
- Key event: tv_prev registers tecla_valida; event = tecla_valida & ~tv_prev. Exactly one event per press, regardless of hold length. tecla is sampled in the event cycle.
- acc is a 10-bit internal register (max 999). Digit accept: acc <= acc*10 + tecla; digitos <= digitos+1.
- State IDLE:
  - Digit event: acc=tecla, digitos=1, go to COLETA.
  - Clear, confirm or ignored-code event: no effect.
- State COLETA:
  - Digit event with digitos<3: accept the digit.
  - Digit event with digitos=3: digit ignored, no error.
  - Clear event: acc=0, digitos=0, go to IDLE.
  - Confirm event with acc<=255: senha<=acc[7:0] at that edge, acc=0, digitos=0, go to ENVIA.
  - Confirm event with acc>255: erro=1 for the next cycle only, acc=0, digitos=0, senha unchanged, go to IDLE.
  - Timeout counter resets to 0 on every event and increments otherwise. On reaching TIMEOUT-1: acc=0, digitos=0, go to IDLE, no erro.
- State ENVIA:
  - enter=1 starting the cycle after the confirm edge, for exactly ENTER_CYCLES clocks, then enter=0 and go to IDLE.
  - senha is stable for the whole enter window and holds its value until the next accepted entry.
  - Key events during ENVIA are ignored entirely. tv_prev still tracks, so a key held across the return to IDLE does not generate an event.
- Latency: confirm event at edge N gives senha valid after N and enter high from after N+1 through N+ENTER_CYCLES.
- Leading zeros are allowed ("007" = 7, 3 digits). A confirm with digitos=0 cannot occur, because it is only reachable from COLETA.
- Reset asserted mid-entry or mid-enter: immediate return to reset values; enter drops asynchronously.

Test Plan:
- Reset, press 2,0,0,# (each press held 3 clocks) -> senha=200 after # edge; enter high 2 clocks starting next cycle; erro=0; digitos steps 1,2,3 then 0.
- Press 3,0,0,# -> erro pulses 1 clock; enter stays 0; senha keeps 200; back to IDLE.
- Press 1,9,9,5,# -> 4th digit ignored; senha=199; digitos never exceeds 3.
- Press 4,5,* then 1,# -> clear returns digitos=0; senha=1, not 451.
- With TIMEOUT=50: press 7, wait 60 clocks, press # -> no enter, no erro; then 8,# -> senha=8.
- Hold tecla_valida=1 on digit 5 for 20 clocks then # -> single digit accepted, senha=5. Separately, assert rst during the enter window -> enter=0 and senha=0 immediately.
